// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, single-cycle integer ALU, branch-target adder
// and an iterative multiply/divide unit that stalls the pipeline while it works.
module ex_stage_md #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_ex,
    input  logic            flush_ex,
    input  logic [XLEN-1:0] imm_ex,
    input  logic [XLEN-1:0] reg_data1_ex,
    input  logic [XLEN-1:0] reg_data2_ex,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [2:0]      funct3_ex,
    input  logic [6:0]      funct7_ex,
    input  logic [1:0]      aluop_ex,
    input  logic            alusrc_ex,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] mem_data,
    output logic            stall_ex,
    output logic            md_done,
    output logic            zero_ex,
    output logic [XLEN-1:0] alu_out_ex,
    output logic [XLEN-1:0] pc_branch_ex,
    output logic [XLEN-1:0] reg_data2_final
);

    localparam int SHW   = $clog2(XLEN);
    localparam int K     = (XLEN + MUL_CYCLES - 1) / MUL_CYCLES;
    localparam int PW    = K * MUL_CYCLES;
    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             done_seen;
    logic [2:0]       md_f3;
    logic             md_sa;
    logic             md_neg;
    logic [XLEN-1:0]  md_a_raw;
    logic [XLEN-1:0]  md_b_mag;
    logic [XLEN+PW-1:0] acc;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  md_result;

    logic [XLEN-1:0]  fwd_a;
    logic [XLEN-1:0]  fwd_b;
    logic [XLEN-1:0]  op_b;
    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  alu_res;

    always_comb begin
        case (forward_a)
            2'b00:   fwd_a = reg_data1_ex;
            2'b01:   fwd_a = wb_data;
            2'b10:   fwd_a = mem_data;
            default: fwd_a = '0;
        endcase
        case (forward_b)
            2'b00:   fwd_b = reg_data2_ex;
            2'b01:   fwd_b = wb_data;
            2'b10:   fwd_b = mem_data;
            default: fwd_b = '0;
        endcase
    end

    assign op_b            = alusrc_ex ? imm_ex : fwd_b;
    assign shamt           = op_b[SHW-1:0];
    assign reg_data2_final = fwd_b;
    assign pc_branch_ex    = pc_ex + imm_ex;

    always_comb begin
        alu_res = '0;
        case (aluop_ex)
            2'b00: alu_res = fwd_a + op_b;
            2'b01: alu_res = fwd_a - op_b;
            2'b11: alu_res = imm_ex;
            default: begin
                case (funct3_ex)
                    3'b000: alu_res = funct7_ex[5] ? (fwd_a - op_b) : (fwd_a + op_b);
                    3'b001: alu_res = fwd_a << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
                    3'b100: alu_res = fwd_a ^ op_b;
                    3'b101: alu_res = funct7_ex[5] ? $unsigned($signed(fwd_a) >>> shamt)
                                                   : (fwd_a >> shamt);
                    3'b110: alu_res = fwd_a | op_b;
                    default: alu_res = fwd_a & op_b;
                endcase
            end
        endcase
    end

    // done_seen blocks a held M-op from re-issuing until the instruction leaves ID/EX
    logic md_req;
    logic issue;
    assign md_req = valid_ex && !flush_ex && (aluop_ex == 2'b10) && (funct7_ex == 7'b0000001);
    assign issue  = (state == S_IDLE) && md_req && !done_seen;

    logic            a_signed;
    logic            b_signed;
    logic            iss_sa;
    logic            iss_sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN+PW-1:0] acc_init;

    always_comb begin
        a_signed = funct3_ex[2] ? !funct3_ex[0] : (funct3_ex[1:0] != 2'b11);
        b_signed = funct3_ex[2] ? !funct3_ex[0] : !funct3_ex[1];
        iss_sa   = a_signed && fwd_a[XLEN-1];
        iss_sb   = b_signed && fwd_b[XLEN-1];
        mag_a    = iss_sa ? -fwd_a : fwd_a;
        mag_b    = iss_sb ? -fwd_b : fwd_b;
        acc_init = '0;
        acc_init[XLEN-1:0] = mag_a;
    end

    // Multiplier: low PW bits of acc hold the remaining multiplier digits, upper
    // XLEN bits accumulate; each step adds mcand*digit and shifts right by K.
    logic [K-1:0]         mul_digit;
    logic [XLEN+K-1:0]    mul_partial;
    logic [XLEN+K-1:0]    mul_sum;
    logic [XLEN+PW-1:0]   acc_next;
    logic [2*XLEN-1:0]    prod_mag;
    logic [2*XLEN-1:0]    prod_fix;
    logic [XLEN-1:0]      mul_final;

    assign mul_digit   = acc[K-1:0];
    assign mul_partial = {{K{1'b0}}, md_b_mag} * {{XLEN{1'b0}}, mul_digit};
    assign mul_sum     = {{K{1'b0}}, acc[XLEN+PW-1:PW]} + mul_partial;

    generate
        if (PW > K) begin : g_mul_shift
            assign acc_next = {mul_sum, acc[PW-1:K]};
        end else begin : g_mul_single
            assign acc_next = mul_sum;
        end
    endgenerate

    assign prod_mag  = acc_next[2*XLEN-1:0];
    assign prod_fix  = md_neg ? -prod_mag : prod_mag;
    assign mul_final = (md_f3[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] div_final;

    assign div_shift = {rem_r, quo_r[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, md_b_mag};

    // A zero divisor always "fits", so the quotient fills with ones on its own;
    // the signed fix-up is bypassed for it so the raw dividend is returned.
    always_comb begin
        if (!div_diff[XLEN]) begin
            rem_next = div_diff[XLEN-1:0];
            quo_next = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_next = div_shift[XLEN-1:0];
            quo_next = {quo_r[XLEN-2:0], 1'b0};
        end
        if (md_b_mag == '0)
            div_final = md_f3[1] ? md_a_raw : '1;
        else if (md_f3[1])
            div_final = md_sa ? -rem_next : rem_next;
        else
            div_final = md_neg ? -quo_next : quo_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            done_seen <= 1'b0;
            md_f3     <= '0;
            md_sa     <= 1'b0;
            md_neg    <= 1'b0;
            md_a_raw  <= '0;
            md_b_mag  <= '0;
            acc       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            md_result <= '0;
        end else if (flush_ex) begin
            state     <= S_IDLE;
            cnt       <= '0;
            done_seen <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        md_f3    <= funct3_ex;
                        md_sa    <= iss_sa;
                        md_neg   <= iss_sa ^ iss_sb;
                        md_a_raw <= fwd_a;
                        md_b_mag <= mag_b;
                        acc      <= acc_init;
                        rem_r    <= '0;
                        quo_r    <= mag_a;
                        cnt      <= '0;
                        state    <= funct3_ex[2] ? S_DIV : S_MUL;
                    end else if (!md_req) begin
                        done_seen <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc <= acc_next;
                    if (cnt == MUL_LAST) begin
                        md_result <= mul_final;
                        cnt       <= '0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    rem_r <= rem_next;
                    quo_r <= quo_next;
                    if (cnt == DIV_LAST) begin
                        md_result <= div_final;
                        cnt       <= '0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    done_seen <= 1'b1;
                end
            endcase
        end
    end

    assign stall_ex   = !reset && !flush_ex && (issue || (state == S_MUL) || (state == S_DIV));
    assign md_done    = !reset && !flush_ex && (state == S_DONE);
    assign alu_out_ex = md_done ? md_result : alu_res;
    assign zero_ex    = (alu_out_ex == '0);

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: directed ALU/forwarding vectors, M-op
// results against a reference model via a scoreboard queue, abort and reset cases.
module tb_ex_stage_md;

    localparam int XLEN       = 32;
    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 32;
    localparam int MUL_LAT    = MUL_CYCLES + 1;
    localparam int DIV_LAT    = XLEN + 1;

    logic            clk;
    logic            reset;
    logic            valid_ex;
    logic            flush_ex;
    logic [XLEN-1:0] imm_ex;
    logic [XLEN-1:0] reg_data1_ex;
    logic [XLEN-1:0] reg_data2_ex;
    logic [XLEN-1:0] pc_ex;
    logic [2:0]      funct3_ex;
    logic [6:0]      funct7_ex;
    logic [1:0]      aluop_ex;
    logic            alusrc_ex;
    logic [1:0]      forward_a;
    logic [1:0]      forward_b;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] mem_data;
    logic            stall_ex;
    logic            md_done;
    logic            zero_ex;
    logic [XLEN-1:0] alu_out_ex;
    logic [XLEN-1:0] pc_branch_ex;
    logic [XLEN-1:0] reg_data2_final;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    ex_stage_md #(
        .XLEN(XLEN),
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_ex(valid_ex),
        .flush_ex(flush_ex),
        .imm_ex(imm_ex),
        .reg_data1_ex(reg_data1_ex),
        .reg_data2_ex(reg_data2_ex),
        .pc_ex(pc_ex),
        .funct3_ex(funct3_ex),
        .funct7_ex(funct7_ex),
        .aluop_ex(aluop_ex),
        .alusrc_ex(alusrc_ex),
        .forward_a(forward_a),
        .forward_b(forward_b),
        .wb_data(wb_data),
        .mem_data(mem_data),
        .stall_ex(stall_ex),
        .md_done(md_done),
        .zero_ex(zero_ex),
        .alu_out_ex(alu_out_ex),
        .pc_branch_ex(pc_branch_ex),
        .reg_data2_final(reg_data2_final)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scoreboardCheck(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard: observed %h with no expected entry queued", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checkOutput(t, obs, e);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic src,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] wb, input logic [31:0] mem,
                                 input logic [31:0] imm);
        valid_ex     = v;
        flush_ex     = 1'b0;
        aluop_ex     = op;
        funct3_ex    = f3;
        funct7_ex    = f7;
        alusrc_ex    = src;
        forward_a    = fa;
        forward_b    = fb;
        reg_data1_ex = r1;
        reg_data2_ex = r2;
        wb_data      = wb;
        mem_data     = mem;
        imm_ex       = imm;
    endtask

    function automatic logic [31:0] mdModel(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [63:0] ubs64;
        logic [63:0]        ua64;
        logic [63:0]        ub64;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa64  = {{32{a[31]}}, a};
        sb64  = {{32{b[31]}}, b};
        ua64  = {32'h0, a};
        ub64  = {32'h0, b};
        ubs64 = ub64;
        sa    = a;
        sb    = b;
        case (f3)
            3'd0: begin p = sa64 * sb64;  return p[31:0];  end
            3'd1: begin p = sa64 * sb64;  return p[63:32]; end
            3'd2: begin p = sa64 * ubs64; return p[63:32]; end
            3'd3: begin p = ua64 * ub64;  return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sr = sa / sb;
                return sr;
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sr = sa % sb;
                return sr;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    task automatic aluCase(input string tag, input logic [1:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic src,
                           input logic [1:0] fa, input logic [1:0] fb,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] wb, input logic [31:0] mem,
                           input logic [31:0] imm, input logic [31:0] exp);
        applyStimulus(1'b1, op, f3, f7, src, fa, fb, r1, r2, wb, mem, imm);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        scoreboardCheck(alu_out_ex);
        checkOutput({tag, " stall"}, {31'b0, stall_ex}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Issue an M-op, wait (bounded) for md_done, check result, latency and stall
    // length, then confirm the held instruction does not issue a second time.
    task automatic runMop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit wiggle);
        int lat;
        int stalls;
        int explat;
        bit done;
        explat = f3[2] ? DIV_LAT : MUL_LAT;
        applyStimulus(1'b1, 2'b10, f3, 7'b0000001, 1'b0, wiggle ? 2'b10 : 2'b00, 2'b00,
                      wiggle ? ~a : a, b, 32'h0, wiggle ? a : 32'h0, 32'h0);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        stalls = stall_ex ? 1 : 0;
        lat    = 0;
        done   = 1'b0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (wiggle) begin
                mem_data = $urandom;
                wb_data  = $urandom;
            end
            #1;
            if (md_done) begin
                done = 1'b1;
                scoreboardCheck(alu_out_ex);
                checkOutput({tag, " latency"}, 32'(lat), 32'(explat));
                checkOutput({tag, " done stall"}, {31'b0, stall_ex}, 32'd0);
                checkOutput({tag, " zero"}, {31'b0, zero_ex}, {31'b0, (exp == 32'h0)});
            end else if (stall_ex) begin
                stalls++;
            end
        end
        vectors++;
        assert (done) else begin
            miscompares++;
            $error("[TB] FAIL %s timeout: observed no md_done after %0d cycles, expected at %0d",
                   tag, lat, explat);
            void'(exp_q.pop_back());
            void'(tag_q.pop_back());
        end
        checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(explat));
        @(posedge clk);
        #2;
        checkOutput({tag, " no reissue"}, {31'b0, stall_ex | md_done}, 32'd0);
        valid_ex = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int busy;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rf;

        reset = 1'b1;
        pc_ex = 32'h0;
        applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("reset stall", {31'b0, stall_ex}, 32'd0);
        checkOutput("reset md_done", {31'b0, md_done}, 32'd0);
        @(posedge clk);
        #1;

        // ALU and forwarding vectors
        aluCase("fwd add",  2'b10, 3'b000, 7'b0000000, 1'b0, 2'b10, 2'b00, 32'd5, 32'd3, 0, 32'd9, 0, 32'd12);
        aluCase("fwd sub",  2'b10, 3'b000, 7'b0100000, 1'b0, 2'b10, 2'b00, 32'd5, 32'd3, 0, 32'd9, 0, 32'd6);
        aluCase("sll",      2'b10, 3'b001, 7'b0000000, 1'b0, 2'b00, 2'b00, 32'd1, 32'h21, 0, 0, 0, 32'd2);
        aluCase("slt",      2'b10, 3'b010, 7'b0000000, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 32'd1);
        aluCase("sltu",     2'b10, 3'b011, 7'b0000000, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 32'd0);
        aluCase("xor",      2'b10, 3'b100, 7'b0000000, 1'b0, 2'b00, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 32'hFF00_FF00);
        aluCase("srl",      2'b10, 3'b101, 7'b0000000, 1'b0, 2'b00, 2'b00, 32'h8000_0000, 32'd4, 0, 0, 0, 32'h0800_0000);
        aluCase("sra",      2'b10, 3'b101, 7'b0100000, 1'b0, 2'b00, 2'b00, 32'h8000_0000, 32'd4, 0, 0, 0, 32'hF800_0000);
        aluCase("or",       2'b10, 3'b110, 7'b0000000, 1'b0, 2'b00, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 32'hFFF0_FFF0);
        aluCase("and",      2'b10, 3'b111, 7'b0000000, 1'b0, 2'b00, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 32'h00F0_00F0);
        aluCase("add imm",  2'b00, 3'b000, 7'b0000000, 1'b1, 2'b00, 2'b00, 32'd10, 32'd99, 0, 0, 32'hFFFF_FFFC, 32'd6);
        aluCase("lui",      2'b11, 3'b000, 7'b0000000, 1'b0, 2'b00, 2'b00, 32'd1, 32'd2, 0, 0, 32'h1234_5000, 32'h1234_5000);

        applyStimulus(1'b1, 2'b01, 3'b000, 7'b0, 1'b0, 2'b00, 2'b00, 32'd7, 32'd7, 0, 0, 0);
        #1;
        checkOutput("sub equal zero_ex", {31'b0, zero_ex}, 32'd1);
        checkOutput("sub equal result", alu_out_ex, 32'd0);

        applyStimulus(1'b1, 2'b10, 3'b000, 7'b0, 1'b0, 2'b11, 2'b01, 32'd77, 32'd88, 32'h55, 32'h66, 0);
        #1;
        checkOutput("fwd zero+wb", alu_out_ex, 32'h55);
        checkOutput("store data wb", reg_data2_final, 32'h55);
        forward_b = 2'b10;
        #1;
        checkOutput("store data mem", reg_data2_final, 32'h66);

        pc_ex  = 32'h100;
        imm_ex = 32'hFFFF_FFF0;
        #1;
        checkOutput("pc_branch", pc_branch_ex, 32'h0000_00F0);
        valid_ex = 1'b0;
        @(posedge clk);
        #1;

        // Multiply / divide
        runMop("mul",        3'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFEB, 1'b0);
        runMop("mulh",       3'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 1'b0);
        runMop("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runMop("mulhu",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        runMop("mul zero",   3'd0, 32'd0,        32'd5,        32'd0,        1'b0);
        runMop("div",        3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);
        runMop("rem",        3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0);
        runMop("divu by 0",  3'd5, 32'd10,       32'd0,        32'hFFFF_FFFF, 1'b0);
        runMop("rem by 0",   3'd6, 32'd10,       32'd0,        32'd10,       1'b0);
        runMop("div ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        runMop("rem ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b0);
        runMop("divu",       3'd5, 32'd100,      32'd7,        32'd14,       1'b0);
        runMop("remu",       3'd7, 32'd100,      32'd7,        32'd2,        1'b0);
        runMop("div isolate", 3'd4, 32'd1000,    32'hFFFF_FFF9, 32'hFFFF_FF72, 1'b1);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            rf = 3'($urandom_range(0, 7));
            runMop($sformatf("rand%0d f3=%0d", i, rf), rf, ra, rb, mdModel(rf, ra, rb), 1'b0);
        end

        // Flush during a divide
        applyStimulus(1'b1, 2'b10, 3'd5, 7'b0000001, 1'b0, 2'b00, 2'b00, 32'd100, 32'd7, 0, 0, 0);
        repeat (11) @(posedge clk);
        #1;
        flush_ex = 1'b1;
        #1;
        checkOutput("flush stall", {31'b0, stall_ex}, 32'd0);
        checkOutput("flush md_done", {31'b0, md_done}, 32'd0);
        @(posedge clk);
        #1;
        flush_ex = 1'b0;
        valid_ex = 1'b0;
        #1;
        checkOutput("post flush stall", {31'b0, stall_ex}, 32'd0);
        pulses = 0;
        busy   = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (md_done) pulses++;
            if (stall_ex) busy++;
        end
        checkOutput("flush no md_done", 32'(pulses), 32'd0);
        checkOutput("flush no stall", 32'(busy), 32'd0);

        // Reset in the middle of a multiply
        applyStimulus(1'b1, 2'b10, 3'd0, 7'b0000001, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        valid_ex = 1'b0;
        #1;
        checkOutput("mid reset stall", {31'b0, stall_ex}, 32'd0);
        checkOutput("mid reset md_done", {31'b0, md_done}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (md_done) pulses++;
        end
        checkOutput("mid reset no md_done", 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
        runMop("mul after reset", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0);

        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
